// File: rtl/pipeline_ctrl_sequencer.sv
// rtl/pipeline_ctrl_sequencer.sv - pipeline stall/flush/PC-select sequencer; optional counters via PIPE_PERF_CNT_EN
module pipeline_ctrl_sequencer #(
  parameter int BR_TIMEOUT = 8,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_mem_busy,
  input  logic             i_load_use,
  input  logic             i_branch_id,
  input  logic             i_br_resolved,
  input  logic             i_br_taken,
  output logic             o_pc_en,
  output logic             o_pc_sel_target,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_en,
  output logic [1:0]       o_ctrl_state,
  output logic             o_br_timeout_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_cycles
`endif
);

  localparam int CW = $clog2(BR_TIMEOUT + 1);
  localparam logic [CW-1:0] LP_CNT_LAST = CW'(BR_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_BR_WAIT  = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        r_ret_state;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  state_t        w_state_nxt;
  state_t        w_ret_nxt;
  state_t        w_eval_state;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_err_set;
  logic          w_pc_en;
  logic          w_pc_sel_target;
  logic          w_if_id_en;
  logic          w_if_id_flush;
  logic          w_id_ex_flush;
  logic          w_ex_mem_en;

  // State register, branch-wait counter and sticky timeout flag
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_RUN;
      r_ret_state <= S_RUN;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err       <= r_err | w_err_set;
    end
  end

  // Next-state and per-stage controls; leaving MEM_WAIT re-evaluates the saved state in the same cycle
  always_comb begin
    w_pc_en         = 1'b1;
    w_pc_sel_target = 1'b0;
    w_if_id_en      = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_en     = 1'b1;
    w_state_nxt     = r_state;
    w_ret_nxt       = r_ret_state;
    w_cnt_nxt       = r_cnt;
    w_err_set       = 1'b0;
    w_eval_state    = r_state;

    if (r_state == S_MEM_WAIT && !i_mem_busy) begin
      w_eval_state = r_ret_state;
    end

    case (w_eval_state)
      S_RUN: begin
        w_state_nxt = S_RUN;
        if (i_mem_busy) begin
          w_pc_en     = 1'b0;
          w_if_id_en  = 1'b0;
          w_ex_mem_en = 1'b0;
          w_ret_nxt   = S_RUN;
          w_state_nxt = S_MEM_WAIT;
        end else if (i_load_use) begin
          // branch_id waits: the branch is still held in IF/ID
          w_pc_en       = 1'b0;
          w_if_id_en    = 1'b0;
          w_id_ex_flush = 1'b1;
        end else if (i_branch_id) begin
          w_pc_en       = 1'b0;
          w_if_id_flush = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_BR_WAIT;
        end
      end
      S_BR_WAIT: begin
        w_state_nxt   = S_BR_WAIT;
        w_pc_en       = 1'b0;
        w_if_id_flush = 1'b1;
        if (i_mem_busy) begin
          // a resolve in this cycle is dropped; EX re-presents it after the freeze
          w_if_id_flush = 1'b0;
          w_if_id_en    = 1'b0;
          w_ex_mem_en   = 1'b0;
          w_ret_nxt     = S_BR_WAIT;
          w_state_nxt   = S_MEM_WAIT;
        end else if (i_br_resolved) begin
          w_pc_en         = 1'b1;
          w_pc_sel_target = i_br_taken;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_RUN;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_err_set   = 1'b1;
          w_pc_en     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_MEM_WAIT: begin
        w_pc_en     = 1'b0;
        w_if_id_en  = 1'b0;
        w_ex_mem_en = 1'b0;
        w_state_nxt = S_MEM_WAIT;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase

    if (!i_reset) begin
      w_pc_en         = 1'b0;
      w_pc_sel_target = 1'b0;
      w_if_id_en      = 1'b0;
      w_ex_mem_en     = 1'b0;
      w_if_id_flush   = 1'b1;
      w_id_ex_flush   = 1'b1;
    end
  end

  assign o_pc_en          = w_pc_en;
  assign o_pc_sel_target  = w_pc_sel_target;
  assign o_if_id_en       = w_if_id_en;
  assign o_if_id_flush    = w_if_id_flush;
  assign o_id_ex_flush    = w_id_ex_flush;
  assign o_ex_mem_en      = w_ex_mem_en;
  assign o_ctrl_state     = r_state;
  assign o_br_timeout_err = r_err;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating stall and flush cycle counters
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if ((w_if_id_flush || w_id_ex_flush) && r_flush_cnt != '1) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_cycles = r_stall_cnt;
  assign o_flush_cycles = r_flush_cnt;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipeline_ctrl_sequencer.sv
// tb/tb_pipeline_ctrl_sequencer.sv - self-checking bench for pipeline_ctrl_sequencer
module tb_pipeline_ctrl_sequencer;

  localparam int BR_TIMEOUT = 8;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n, mem_busy, load_use, branch_id, br_resolved, br_taken;
  logic       pc_en, pc_sel_target, if_id_en, if_id_flush, id_ex_flush, ex_mem_en;
  logic [1:0] ctrl_state;
  logic       br_timeout_err;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles, flush_cycles;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl_sequencer #(.BR_TIMEOUT(BR_TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_mem_busy      (mem_busy),
    .i_load_use      (load_use),
    .i_branch_id     (branch_id),
    .i_br_resolved   (br_resolved),
    .i_br_taken      (br_taken),
    .o_pc_en         (pc_en),
    .o_pc_sel_target (pc_sel_target),
    .o_if_id_en      (if_id_en),
    .o_if_id_flush   (if_id_flush),
    .o_id_ex_flush   (id_ex_flush),
    .o_ex_mem_en     (ex_mem_en),
    .o_ctrl_state    (ctrl_state),
    .o_br_timeout_err(br_timeout_err)
`ifdef PIPE_PERF_CNT_EN
    ,
    .o_stall_cycles  (stall_cycles),
    .o_flush_cycles  (flush_cycles)
`endif
  );

  // inputs:  {rst_n, mem_busy, load_use, branch_id, br_resolved, br_taken}
  // outputs: {pc_en, sel, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, state[1:0], err}
  typedef struct {
    logic [5:0] in;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: pending-branch / frozen flags and elapsed wait cycles
  bit m_pend, m_frozen, m_err;
  int m_wait, m_stall, m_flush;

  task automatic add(input logic [5:0] in, input logic [8:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [5:0] in);
    {rst_n, mem_busy, load_use, branch_id, br_resolved, br_taken} = in;
  endtask

  function automatic logic [8:0] act_vec();
    return {pc_en, pc_sel_target, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, ctrl_state, br_timeout_err};
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b required %b", name, idx, act[8:0], exp[8:0]);
    end
  endtask

  task automatic model_clear();
    m_pend = 0; m_frozen = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model(input logic [5:0] in, output logic [8:0] exp, output int exp_stall, output int exp_flush);
    bit rst, busy, lu, bid, res, tk;
    bit pc, sel, ifen, iffl, iefl, emen, err_old;
    int st;
    {rst, busy, lu, bid, res, tk} = in;
    st = m_frozen ? 2 : (m_pend ? 1 : 0);
    err_old = m_err;
    exp_stall = m_stall;
    exp_flush = m_flush;
    pc = 1; sel = 0; ifen = 1; iffl = 0; iefl = 0; emen = 1;
    if (!rst) begin
      pc = 0; ifen = 0; emen = 0; iffl = 1; iefl = 1;
      model_clear();
    end else begin
      if (busy) begin
        pc = 0; ifen = 0; emen = 0;
        m_frozen = 1;
      end else begin
        m_frozen = 0;
        if (m_pend) begin
          iffl = 1;
          if (res) begin
            sel = tk;
            m_pend = 0;
          end else if (m_wait == BR_TIMEOUT - 1) begin
            m_pend = 0;
            m_err = 1;
          end else begin
            pc = 0;
            m_wait++;
          end
        end else if (lu) begin
          pc = 0; ifen = 0; iefl = 1;
        end else if (bid) begin
          pc = 0; iffl = 1;
          m_pend = 1;
          m_wait = 0;
        end
      end
      if (!pc && m_stall < CNT_MAX) m_stall++;
      if ((iffl || iefl) && m_flush < CNT_MAX) m_flush++;
    end
    exp = {pc, sel, ifen, iffl, iefl, emen, 2'(st), err_old};
  endtask

  initial begin
    logic [5:0] in;
    logic [8:0] exp;
    int es, ef;

    drive(6'b0_0_0_0_0_0);
    @(posedge clk); #1;

    // reset and release
    add(6'b0_0_0_0_0_0, 9'b0_0_0_1_1_0_00_0);
    add(6'b0_0_0_0_0_0, 9'b0_0_0_1_1_0_00_0);
    add(6'b1_0_0_0_0_0, 9'b1_0_1_0_0_1_00_0);
    // load_use defers branch_id, then branch enters BR_WAIT
    add(6'b1_0_1_1_0_0, 9'b0_0_0_0_1_1_00_0);
    add(6'b1_0_0_1_0_0, 9'b0_0_1_1_0_1_00_0);
    add(6'b1_0_0_0_0_0, 9'b0_0_1_1_0_1_01_0);
    add(6'b1_0_0_0_0_0, 9'b0_0_1_1_0_1_01_0);
    add(6'b1_0_0_0_1_1, 9'b1_1_1_1_0_1_01_0);
    add(6'b1_0_0_0_0_0, 9'b1_0_1_0_0_1_00_0);
    // freeze inside BR_WAIT, then not-taken resolve on the exit cycle
    add(6'b1_0_0_1_0_0, 9'b0_0_1_1_0_1_00_0);
    add(6'b1_0_0_0_0_0, 9'b0_0_1_1_0_1_01_0);
    add(6'b1_0_0_0_0_0, 9'b0_0_1_1_0_1_01_0);
    add(6'b1_1_0_0_1_1, 9'b0_0_0_0_0_0_01_0);
    add(6'b1_1_0_0_0_0, 9'b0_0_0_0_0_0_10_0);
    add(6'b1_1_0_0_0_0, 9'b0_0_0_0_0_0_10_0);
    add(6'b1_1_0_0_0_0, 9'b0_0_0_0_0_0_10_0);
    add(6'b1_0_0_0_1_0, 9'b1_0_1_1_0_1_10_0);
    add(6'b1_0_0_0_0_0, 9'b1_0_1_0_0_1_00_0);
    // freeze after 2 waits, counter resumes from 2 and times out on the 8th wait cycle
    add(6'b1_0_0_1_0_0, 9'b0_0_1_1_0_1_00_0);
    add(6'b1_0_0_0_0_0, 9'b0_0_1_1_0_1_01_0);
    add(6'b1_0_0_0_0_0, 9'b0_0_1_1_0_1_01_0);
    add(6'b1_1_0_0_0_0, 9'b0_0_0_0_0_0_01_0);
    add(6'b1_1_0_0_0_0, 9'b0_0_0_0_0_0_10_0);
    add(6'b1_0_0_0_0_0, 9'b0_0_1_1_0_1_10_0);
    for (int i = 0; i < 4; i++) add(6'b1_0_0_0_0_0, 9'b0_0_1_1_0_1_01_0);
    add(6'b1_0_0_0_0_0, 9'b1_0_1_1_0_1_01_0);
    add(6'b1_0_0_0_0_0, 9'b1_0_1_0_0_1_00_1);
    // br_resolved in RUN ignored; mem_busy beats load_use; MEM exit honours load_use
    add(6'b1_0_0_0_1_1, 9'b1_0_1_0_0_1_00_1);
    add(6'b1_1_1_0_0_0, 9'b0_0_0_0_0_0_00_1);
    add(6'b1_0_1_0_0_0, 9'b0_0_0_0_1_1_10_1);
    // load_use/branch_id ignored in BR_WAIT; reset mid MEM_WAIT clears everything
    add(6'b1_0_0_1_0_0, 9'b0_0_1_1_0_1_00_1);
    add(6'b1_0_1_1_0_0, 9'b0_0_1_1_0_1_01_1);
    add(6'b1_1_0_0_0_0, 9'b0_0_0_0_0_0_01_1);
    add(6'b0_1_0_0_0_0, 9'b0_0_0_1_1_0_10_1);
    add(6'b1_0_0_0_0_0, 9'b1_0_1_0_0_1_00_0);

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      #4;
      check("table", i, 32'(act_vec()), 32'(vecs[i].exp));
      @(posedge clk); #1;
    end

`ifdef PIPE_PERF_CNT_EN
    drive(6'b0_0_0_0_0_0);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      drive(6'b1_0_1_0_0_0);
      @(posedge clk); #1;
    end
    drive(6'b1_0_0_0_0_0);
    #4;
    check("stall_sat", 0, 32'(stall_cycles), 32'((20 > CNT_MAX) ? CNT_MAX : 20));
    check("flush_sat", 0, 32'(flush_cycles), 32'((20 > CNT_MAX) ? CNT_MAX : 20));
    @(posedge clk); #1;
`endif

    drive(6'b0_0_0_0_0_0);
    @(posedge clk); #1;
    model_clear();
    for (int k = 0; k < 3000; k++) begin
      in[5] = ($urandom_range(99) != 0);
      in[4] = ($urandom_range(5) == 0);
      in[3] = ($urandom_range(4) == 0);
      in[2] = ($urandom_range(3) == 0);
      in[1] = ($urandom_range(5) == 0);
      in[0] = 1'($urandom_range(1));
      drive(in);
      #4;
      model(in, exp, es, ef);
      check("random", k, 32'(act_vec()), 32'(exp));
`ifdef PIPE_PERF_CNT_EN
      check("rand_stall", k, 32'(stall_cycles), 32'(es));
      check("rand_flush", k, 32'(flush_cycles), 32'(ef));
`endif
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
